xlite_regbank: RTL and testbench
================================

XLITE_REGBANK -- requirements
Module: xlite_regbank

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, entries per queue (power of 2, 2..64).
REQ-002 SHALL have parameter ID_VALUE, default 32'h584C_5242, constant returned by the ID register.
REQ-003 SHALL have port user_clk  in  1  sole clock, the Xillybus Lite user clock.
REQ-004 SHALL have port user_rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port user_wren  in  1  host write strobe, one cycle per write.
REQ-006 SHALL have port user_wstrb  in  4  byte enables for the write.
REQ-007 SHALL have port user_rden  in  1  host read strobe, one cycle per read.
REQ-008 SHALL have port user_addr  in  32  byte address; only bits [4:2] decoded.
REQ-009 SHALL have port user_wr_data  in  32  write data.
REQ-010 SHALL have port user_rd_data  out  32  read data.
REQ-011 SHALL have port user_irq  out  1  level interrupt to host.
REQ-012 SHALL have ports tx_data out 32, tx_valid out 1, tx_ready in 1: host-to-logic stream, transfer when valid and ready.
REQ-013 SHALL have ports rx_data in 32, rx_valid in 1, rx_ready out 1: logic-to-host stream, transfer when valid and ready.

Function
REQ-014 Register map (offset): 0x00 SCRATCH RW; 0x04 STATUS RO; 0x08 TXQ WO; 0x0C RXQ RO; 0x10 IRQ_PEND W1C; 0x14 IRQ_MASK RW; 0x18 ID RO; 0x1C CTRL (REQ-027).
REQ-015 user_rd_data SHALL be registered, valid the cycle after user_rden, held until the next read; unmapped or WO offsets read 0.
REQ-016 SCRATCH and IRQ_MASK writes SHALL honour user_wstrb per byte; IRQ_MASK bits [31:3] read 0.
REQ-017 STATUS SHALL read {rxq_count[19:16], txq_count[11:8], rxq_empty[3], rxq_full[2], txq_empty[1], txq_full[0]}, other bits 0; counts width log2(FIFO_DEPTH)+1, zero-extended into fields.
REQ-018 TXQ write with user_wstrb==4'hF SHALL push user_wr_data; other strobe patterns SHALL be ignored; push when full SHALL drop the word and set IRQ_PEND[1].
REQ-019 RXQ read SHALL pop in the user_rden cycle and return the popped word next cycle; read when empty SHALL return 0, not pop, and set IRQ_PEND[2].
REQ-020 tx_valid = TX queue not empty; tx_data = head word; rx_ready = RX queue not full.
REQ-021 Simultaneous push and pop on one queue SHALL both occur, count unchanged; pop-side empty and push-side full SHALL be evaluated on the pre-cycle count.
REQ-022 IRQ_PEND[0] SHALL set on the cycle RX queue goes empty→non-empty; writing 1 clears a bit; a set event coinciding with the clear SHALL win.
REQ-023 user_irq SHALL be registered |(IRQ_PEND & IRQ_MASK), one cycle after pend/mask change.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; counts never exceed FIFO_DEPTH or underflow.

Reset
REQ-025 user_rst SHALL asynchronously clear queues, SCRATCH, IRQ_PEND, IRQ_MASK, CTRL, user_rd_data, user_irq; tx_valid=0, rx_ready=0 while user_rst high, rx_ready=1 from first cycle after release.
REQ-026 Reset mid-transfer SHALL discard queued words; no stream transfer occurs in the reset-release cycle.

Configuration
REQ-027 With XLITE_REGBANK_LOOPBACK_EN defined, CTRL[0] (RW) SHALL route TX queue head into RX queue internally (tx_valid=0, rx_ready=0, external streams idle); without it CTRL reads 0 and writes are ignored.

Structure
REQ-028 Package xlite_regbank_pkg SHALL hold register offsets, STATUS/IRQ bit positions and the default ID constant.
REQ-029 Both queues SHALL instantiate one sub-module xlite_sync_fifo (FIFO_DEPTH, 32-bit, count output).

Verification
REQ-030 Write SCRATCH 0xDEADBEEF strobe 4'b0101 after reset -> read returns 0x00AD00EF one cycle after rden.
REQ-031 Push 9 words 1..9 to TXQ, tx_ready=0 -> STATUS txq_full=1, count 8, IRQ_PEND=0x2; release tx_ready -> tx_data 1..8 in order.
REQ-032 Drive rx word 0x1234, IRQ_MASK=1 -> user_irq high two cycles after transfer; read RXQ -> 0x1234; write IRQ_PEND=1 -> user_irq low.
REQ-033 Read RXQ when empty -> data 0, IRQ_PEND[2]=1, count stays 0; W1C on same cycle as new underflow -> bit remains 1.
REQ-034 Assert user_rst with 5 words queued -> STATUS reads 0x0000_000A after release.
REQ-035 With XLITE_REGBANK_LOOPBACK_EN, CTRL=1, push 0xA5A5 to TXQ -> RXQ read returns 0xA5A5, tx_valid never asserted.

Source files
------------

// File: rtl/xlite_regbank_pkg.sv
// xlite_regbank_pkg: shared constants for the Xillybus Lite register bank.
// Holds byte offsets of every register, STATUS field positions, IRQ_PEND
// bit positions and the default ID constant.
package xlite_regbank_pkg;

   localparam int unsigned DATA_W = 32;

   // Register byte offsets (only address bits [4:2] are decoded)
   localparam logic [4:0] OFF_SCRATCH  = 5'h00;
   localparam logic [4:0] OFF_STATUS   = 5'h04;
   localparam logic [4:0] OFF_TXQ      = 5'h08;
   localparam logic [4:0] OFF_RXQ      = 5'h0C;
   localparam logic [4:0] OFF_IRQ_PEND = 5'h10;
   localparam logic [4:0] OFF_IRQ_MASK = 5'h14;
   localparam logic [4:0] OFF_ID       = 5'h18;
   localparam logic [4:0] OFF_CTRL     = 5'h1C;

   // STATUS bit positions; counts are LSB positions of zero-extended fields
   localparam int unsigned ST_TXQ_FULL  = 0;
   localparam int unsigned ST_TXQ_EMPTY = 1;
   localparam int unsigned ST_RXQ_FULL  = 2;
   localparam int unsigned ST_RXQ_EMPTY = 3;
   localparam int unsigned ST_TXQ_COUNT = 8;
   localparam int unsigned ST_RXQ_COUNT = 16;

   // IRQ_PEND / IRQ_MASK bit positions
   localparam int unsigned IRQ_RX_AVAIL = 0;
   localparam int unsigned IRQ_TX_OVF   = 1;
   localparam int unsigned IRQ_RX_UNF   = 2;
   localparam int unsigned IRQ_W        = 3;

   localparam logic [DATA_W-1:0] ID_DEFAULT = 32'h584C_5242;

endpackage

// File: rtl/xlite_sync_fifo.sv
// xlite_sync_fifo: single-clock FIFO with occupancy count.
// Ports: clk, rst (async active-high); push/wr_data write side; pop/rd_data_c
// read side (rd_data_c is the current head word); full_c/empty_c decoded from
// the registered count; count = number of stored words (0..DEPTH).
// A push while full or a pop while empty is ignored, judged on the count at
// the start of the cycle, so push+pop together leave the count unchanged.
module xlite_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full_c    = (count == CW'(DEPTH));
   assign empty_c   = (count == '0);
   assign do_push   = push & ~full_c;
   assign do_pop    = pop & ~empty_c;
   assign rd_data_c = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Storage needs no reset; contents are only visible while count != 0
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/xlite_regbank.sv
// xlite_regbank: Xillybus Lite register bank with TX/RX stream queues.
// Ports: user_clk, user_rst (async active-high); host bus user_wren,
// user_wstrb, user_rden, user_addr, user_wr_data, user_rd_data (registered);
// user_irq (registered level interrupt); tx_data/tx_valid/tx_ready
// host-to-logic stream; rx_data/rx_valid/rx_ready logic-to-host stream.
// Optional feature: define XLITE_REGBANK_LOOPBACK_EN to make CTRL[0] route
// the TX queue head straight into the RX queue.
module xlite_regbank
   import xlite_regbank_pkg::*;
#(
   parameter int unsigned        FIFO_DEPTH = 8,
   parameter logic [DATA_W-1:0]  ID_VALUE   = ID_DEFAULT
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic              user_wren,
   input  logic [3:0]        user_wstrb,
   input  logic              user_rden,
   input  logic [31:0]       user_addr,
   input  logic [31:0]       user_wr_data,
   output logic [31:0]       user_rd_data,
   output logic              user_irq,
   output logic [31:0]       tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [31:0]       rx_data,
   input  logic              rx_valid,
   output logic              rx_ready
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [4:0]        off;
   logic              unused_addr;
   logic              run_q;
   logic [31:0]       scratch_q;
   logic [IRQ_W-1:0]  pend_q, mask_q, pend_set, pend_clr;
   logic              wr_scratch, wr_mask, wr_pend, wr_txq, rd_rxq;
   logic              lb_en, lb_xfer;
   logic              tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [31:0]       rx_head, rx_push_data, status, rd_mux;
   logic [CW-1:0]     tx_count, rx_count;

   assign off         = {user_addr[4:2], 2'b00};
   assign unused_addr = &{1'b0, user_addr[31:5], user_addr[1:0]};

   assign wr_scratch  = user_wren && (off == OFF_SCRATCH);
   assign wr_mask     = user_wren && (off == OFF_IRQ_MASK);
   assign wr_pend     = user_wren && (off == OFF_IRQ_PEND);
   assign wr_txq      = user_wren && (off == OFF_TXQ);
   assign rd_rxq      = user_rden && (off == OFF_RXQ);

`ifdef XLITE_REGBANK_LOOPBACK_EN
   logic wr_ctrl;
   logic ctrl_q;
   assign wr_ctrl = user_wren && (off == OFF_CTRL);
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst)                     ctrl_q <= 1'b0;
      else if (wr_ctrl && user_wstrb[0]) ctrl_q <= user_wr_data[0];
   end
   assign lb_en = ctrl_q;
`else
   assign lb_en = 1'b0;
`endif

   // run_q keeps both streams idle in reset and in the reset-release cycle
   assign tx_valid     = run_q & ~tx_empty & ~lb_en;
   assign rx_ready     = run_q & ~rx_full & ~lb_en;
   assign lb_xfer      = run_q & lb_en & ~tx_empty & ~rx_full;

   assign tx_push_req  = wr_txq && (user_wstrb == 4'hF);
   assign tx_push      = tx_push_req & ~tx_full;
   assign tx_pop       = (tx_valid & tx_ready) | lb_xfer;
   assign rx_push      = (rx_valid & rx_ready) | lb_xfer;
   assign rx_push_data = lb_en ? tx_data : rx_data;
   assign rx_pop       = rd_rxq & ~rx_empty;

   xlite_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_txq (
      .clk(user_clk), .rst(user_rst),
      .push(tx_push), .wr_data(user_wr_data),
      .pop(tx_pop), .rd_data_c(tx_data),
      .full_c(tx_full), .empty_c(tx_empty), .count(tx_count)
   );

   xlite_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rxq (
      .clk(user_clk), .rst(user_rst),
      .push(rx_push), .wr_data(rx_push_data),
      .pop(rx_pop), .rd_data_c(rx_head),
      .full_c(rx_full), .empty_c(rx_empty), .count(rx_count)
   );

   // Interrupt events; all are judged on pre-cycle queue state
   always_comb begin
      pend_set               = '0;
      pend_set[IRQ_RX_AVAIL] = rx_push & rx_empty;
      pend_set[IRQ_TX_OVF]   = tx_push_req & tx_full;
      pend_set[IRQ_RX_UNF]   = rd_rxq & rx_empty;
      pend_clr               = '0;
      if (wr_pend && user_wstrb[0]) pend_clr = user_wr_data[IRQ_W-1:0];
   end

   always_comb begin
      status                     = '0;
      status[ST_TXQ_FULL]        = tx_full;
      status[ST_TXQ_EMPTY]       = tx_empty;
      status[ST_RXQ_FULL]        = rx_full;
      status[ST_RXQ_EMPTY]       = rx_empty;
      status[ST_TXQ_COUNT +: CW] = tx_count;
      status[ST_RXQ_COUNT +: CW] = rx_count;
   end

   // Read mux; TXQ and unmapped offsets fall through to zero
   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_SCRATCH:  rd_mux = scratch_q;
         OFF_STATUS:   rd_mux = status;
         OFF_RXQ:      rd_mux = rx_empty ? 32'h0 : rx_head;
         OFF_IRQ_PEND: rd_mux = 32'(pend_q);
         OFF_IRQ_MASK: rd_mux = 32'(mask_q);
         OFF_ID:       rd_mux = ID_VALUE;
         OFF_CTRL:     rd_mux = 32'(lb_en);
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         run_q        <= 1'b0;
         scratch_q    <= '0;
         pend_q       <= '0;
         mask_q       <= '0;
         user_rd_data <= '0;
         user_irq     <= 1'b0;
      end else begin
         run_q <= 1'b1;
         for (int b = 0; b < 4; b++) begin
            if (wr_scratch && user_wstrb[b]) scratch_q[8*b +: 8] <= user_wr_data[8*b +: 8];
         end
         if (wr_mask && user_wstrb[0]) mask_q <= user_wr_data[IRQ_W-1:0];
         // Set events win over a coincident write-one-to-clear
         pend_q   <= (pend_q & ~pend_clr) | pend_set;
         user_irq <= |(pend_q & mask_q);
         if (user_rden) user_rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_xlite_regbank.sv
// tb_xlite_regbank: self-checking bench for xlite_regbank, directed scenarios
// plus a randomized run checked against a queue-based reference model.
module tb_xlite_regbank;
   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] ID    = 32'h584C_5242;
   localparam logic [31:0] A_SCRATCH = 32'h00, A_STATUS = 32'h04, A_TXQ = 32'h08,
                           A_RXQ = 32'h0C, A_PEND = 32'h10, A_MASK = 32'h14,
                           A_ID = 32'h18, A_CTRL = 32'h1C;

   logic        user_clk = 1'b0;
   logic        user_rst = 1'b1;
   logic        user_wren = 1'b0, user_rden = 1'b0;
   logic [3:0]  user_wstrb = 4'h0;
   logic [31:0] user_addr = '0, user_wr_data = '0, user_rd_data;
   logic        user_irq;
   logic [31:0] tx_data, rx_data = '0;
   logic        tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;

   int total = 0;
   int bad = 0;

   always #5 user_clk = ~user_clk;

   xlite_regbank #(.FIFO_DEPTH(DEPTH), .ID_VALUE(ID)) dut (
      .user_clk(user_clk), .user_rst(user_rst), .user_wren(user_wren),
      .user_wstrb(user_wstrb), .user_rden(user_rden), .user_addr(user_addr),
      .user_wr_data(user_wr_data), .user_rd_data(user_rd_data),
      .user_irq(user_irq), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready)
   );

   task automatic tick;
      @(posedge user_clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      user_addr = a; user_wr_data = d; user_wstrb = s; user_wren = 1'b1;
      tick();
      user_wren = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      user_addr = a; user_rden = 1'b1;
      tick();
      user_rden = 1'b0;
      d = user_rd_data;
   endtask

   task automatic do_reset;
      user_rst = 1'b1;
      tick();
      user_rst = 1'b0;
      tick();
      tick();
   endtask

   function automatic logic [31:0] status_of(input int ntx, input int nrx);
      return 32'((nrx << 16) | (ntx << 8) | (int'(nrx == 0) << 3) |
                 (int'(nrx == DEPTH) << 2) | (int'(ntx == 0) << 1) | int'(ntx == DEPTH));
   endfunction

   task automatic test_reset;
      logic [31:0] d;
      user_rst = 1'b1;
      tick(); tick();
      total++; if (user_rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data: got %h expected 0", user_rd_data); end
      total++; if (user_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", user_irq); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
      user_rst = 1'b0;
      #1;
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL release_cycle_rx_ready: got %b expected 0", rx_ready); end
      tick();
      total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL post_release_rx_ready: got %b expected 1", rx_ready); end
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_000A) begin bad++; $display("FAIL reset_status: got %h expected 0000000a", d); end
   endtask

   task automatic test_scratch;
      logic [31:0] d, wd, m, a, hi;
      logic [3:0]  s;
      bus_write(A_SCRATCH, 32'hDEADBEEF, 4'b0101);
      bus_read(A_SCRATCH, d);
      total++; if (d !== 32'h00AD00EF) begin bad++; $display("FAIL scratch_strobe: got %h expected 00ad00ef", d); end
      m = 32'h00AD00EF;
      for (int i = 0; i < 8; i++) begin
         wd = $urandom; s = 4'($urandom_range(0, 15)); hi = $urandom;
         a = {hi[31:5], 3'b000, hi[1:0]};
         bus_write(a, wd, s);
         for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = wd[8*b +: 8];
         hi = $urandom;
         bus_read({hi[31:5], 3'b000, hi[1:0]}, d);
         total++; if (d !== m) begin bad++; $display("FAIL scratch_rand: got %h expected %h", d, m); end
      end
      tick(); tick();
      total++; if (user_rd_data !== m) begin bad++; $display("FAIL rd_data_hold: got %h expected %h", user_rd_data, m); end
      bus_read(A_ID, d);
      total++; if (d !== ID) begin bad++; $display("FAIL id: got %h expected %h", d, ID); end
      bus_read(A_TXQ, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL txq_read_zero: got %h expected 0", d); end
      bus_write(A_MASK, 32'hFFFF_FFFF, 4'hF);
      bus_read(A_MASK, d);
      total++; if (d !== 32'h7) begin bad++; $display("FAIL mask_width: got %h expected 7", d); end
      bus_write(A_MASK, 32'h0, 4'b1110);
      bus_read(A_MASK, d);
      total++; if (d !== 32'h7) begin bad++; $display("FAIL mask_strobe: got %h expected 7", d); end
      bus_write(A_MASK, 32'h0, 4'hF);
   endtask

   task automatic test_txq_full;
      logic [31:0] d;
      logic [31:0] q[$];
      tx_ready = 1'b0;
      bus_write(A_TXQ, 32'h77, 4'h7);
      for (int i = 1; i <= 9; i++) begin
         bus_write(A_TXQ, 32'(i), 4'hF);
         if (i <= DEPTH) q.push_back(32'(i));
      end
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_0809) begin bad++; $display("FAIL txq_full_status: got %h expected 00000809", d); end
      bus_read(A_PEND, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL txq_ovf_pend: got %h expected 2", d); end
      tx_ready = 1'b1;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         if (tx_valid === 1'b1) begin
            total++; if (tx_data !== q[0]) begin bad++; $display("FAIL tx_order: got %h expected %h", tx_data, q[0]); end
            void'(q.pop_front());
         end
         tick();
      end
      total++; if (q.size() != 0) begin bad++; $display("FAIL tx_drain_timeout: got %0d left expected 0", q.size()); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_empty_valid: got %b expected 0", tx_valid); end
      tx_ready = 1'b0;
      bus_write(A_PEND, 32'h7, 4'hF);
      bus_read(A_PEND, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL pend_clear: got %h expected 0", d); end
   endtask

   task automatic test_rx_irq;
      logic [31:0] d;
      bus_write(A_MASK, 32'h1, 4'hF);
      rx_data = 32'h1234; rx_valid = 1'b1;
      total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_idle: got %b expected 1", rx_ready); end
      tick();
      rx_valid = 1'b0;
      total++; if (user_irq !== 1'b0) begin bad++; $display("FAIL irq_lag: got %b expected 0", user_irq); end
      tick();
      total++; if (user_irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b expected 1", user_irq); end
      bus_read(A_RXQ, d);
      total++; if (d !== 32'h1234) begin bad++; $display("FAIL rxq_word: got %h expected 00001234", d); end
      bus_write(A_PEND, 32'h1, 4'hF);
      tick();
      total++; if (user_irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b expected 0", user_irq); end
      bus_write(A_MASK, 32'h0, 4'hF);
   endtask

   task automatic test_rx_underflow;
      logic [31:0] d, w;
      bus_read(A_RXQ, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL unf_data: got %h expected 0", d); end
      bus_read(A_PEND, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL unf_pend: got %h expected 4", d); end
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_000A) begin bad++; $display("FAIL unf_status: got %h expected 0000000a", d); end
      w = $urandom;
      rx_data = w; rx_valid = 1'b1;
      bus_write(A_PEND, 32'h1, 4'hF);
      rx_valid = 1'b0;
      bus_read(A_PEND, d);
      total++; if (d !== 32'h5) begin bad++; $display("FAIL set_beats_clear: got %h expected 5", d); end
      bus_write(A_PEND, 32'h7, 4'hF);
      bus_read(A_RXQ, d);
      total++; if (d !== w) begin bad++; $display("FAIL rx_after_w1c: got %h expected %h", d, w); end
      bus_read(A_PEND, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL pend_after_read: got %h expected 0", d); end
   endtask

   task automatic test_reset_midflight;
      logic [31:0] d;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) bus_write(A_TXQ, $urandom, 4'hF);
      rx_data = 32'hCAFE; rx_valid = 1'b1;
      tick(); tick();
      rx_valid = 1'b0;
      bus_write(A_SCRATCH, 32'h5555_5555, 4'hF);
      bus_write(A_MASK, 32'h7, 4'hF);
      tick();
      #3 user_rst = 1'b1;
      #1;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL async_tx_valid: got %b expected 0", tx_valid); end
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL async_rx_ready: got %b expected 0", rx_ready); end
      total++; if (user_irq !== 1'b0) begin bad++; $display("FAIL async_irq: got %b expected 0", user_irq); end
      tick();
      user_rst = 1'b0;
      tick(); tick();
      bus_read(A_STATUS, d);
      total++; if (d !== 32'h0000_000A) begin bad++; $display("FAIL midflight_status: got %h expected 0000000a", d); end
      bus_read(A_SCRATCH, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL midflight_scratch: got %h expected 0", d); end
      bus_read(A_MASK, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL midflight_mask: got %h expected 0", d); end
   endtask

   task automatic test_loopback;
      logic [31:0] d;
      bus_write(A_CTRL, 32'h1, 4'hF);
      bus_read(A_CTRL, d);
`ifdef XLITE_REGBANK_LOOPBACK_EN
      total++; if (d !== 32'h1) begin bad++; $display("FAIL ctrl_rw: got %h expected 1", d); end
      tx_ready = 1'b1;
      bus_write(A_TXQ, 32'hA5A5, 4'hF);
      for (int c = 0; c < 4; c++) begin
         total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL lb_tx_valid: got %b expected 0", tx_valid); end
         total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL lb_rx_ready: got %b expected 0", rx_ready); end
         tick();
      end
      tx_ready = 1'b0;
      bus_read(A_RXQ, d);
      total++; if (d !== 32'hA5A5) begin bad++; $display("FAIL lb_data: got %h expected 0000a5a5", d); end
      bus_write(A_CTRL, 32'h0, 4'hF);
      bus_write(A_PEND, 32'h7, 4'hF);
`else
      total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_absent: got %h expected 0", d); end
      tx_ready = 1'b0;
      bus_write(A_TXQ, 32'hA5A5, 4'hF);
      total++; if (tx_valid !== 1'b1 || tx_data !== 32'hA5A5) begin
         bad++; $display("FAIL no_lb_tx: got %b/%h expected 1/0000a5a5", tx_valid, tx_data);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL no_lb_drain: got %b expected 0", tx_valid); end
`endif
   endtask

   task automatic test_random;
      logic [31:0] txq[$], rxq[$];
      logic [2:0]  pend, pend_lag;
      logic [31:0] exp_rd, d, wd;
      logic [3:0]  s;
      bit          rd_chk, phase_fill;
      int          op, ntx, nrx;
      do_reset();
      bus_write(A_MASK, 32'h7, 4'hF);
      pend = '0; pend_lag = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         ntx = txq.size(); nrx = rxq.size();
         phase_fill = (cyc % 100) < 50;
         total++; if (tx_valid !== (ntx != 0)) begin bad++; $display("FAIL rnd_tx_valid: cyc %0d got %b expected %b", cyc, tx_valid, ntx != 0); end
         if (ntx != 0) begin
            total++; if (tx_data !== txq[0]) begin bad++; $display("FAIL rnd_tx_data: cyc %0d got %h expected %h", cyc, tx_data, txq[0]); end
         end
         total++; if (rx_ready !== (nrx < DEPTH)) begin bad++; $display("FAIL rnd_rx_ready: cyc %0d got %b expected %b", cyc, rx_ready, nrx < DEPTH); end
         total++; if (user_irq !== (|pend_lag)) begin bad++; $display("FAIL rnd_irq: cyc %0d got %b expected %b", cyc, user_irq, |pend_lag); end
         pend_lag = pend;
         tx_ready = ($urandom_range(0, 99) < (phase_fill ? 20 : 80));
         rx_valid = ($urandom_range(0, 99) < (phase_fill ? 70 : 30));
         rx_data  = $urandom;
         user_wren = 1'b0; user_rden = 1'b0; rd_chk = 1'b0; exp_rd = '0;
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            wd = $urandom;
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            user_addr = A_TXQ; user_wr_data = wd; user_wstrb = s; user_wren = 1'b1;
            if (s == 4'hF) begin
               if (ntx < DEPTH) txq.push_back(wd);
               else pend[1] = 1'b1;
            end
         end else if (op <= 5) begin
            user_addr = A_RXQ; user_rden = 1'b1; rd_chk = 1'b1;
            if (nrx > 0) begin exp_rd = rxq[0]; void'(rxq.pop_front()); end
            else pend[2] = 1'b1;
         end else if (op == 6) begin
            user_addr = A_STATUS; user_rden = 1'b1; rd_chk = 1'b1;
            exp_rd = status_of(ntx, nrx);
         end else if (op == 7) begin
            wd = 32'($urandom_range(0, 7));
            user_addr = A_PEND; user_wr_data = wd; user_wstrb = 4'hF; user_wren = 1'b1;
            pend = pend & ~wd[2:0];
         end
         if (ntx != 0 && tx_ready) void'(txq.pop_front());
         if (rx_valid && nrx < DEPTH) begin
            if (nrx == 0) pend[0] = 1'b1;
            rxq.push_back(rx_data);
         end
         tick();
         if (rd_chk) begin
            total++; if (user_rd_data !== exp_rd) begin bad++; $display("FAIL rnd_read: cyc %0d got %h expected %h", cyc, user_rd_data, exp_rd); end
         end
      end
      user_wren = 1'b0; user_rden = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
      bus_read(A_PEND, d);
      total++; if (d !== 32'(pend)) begin bad++; $display("FAIL rnd_pend_final: got %h expected %h", d, pend); end
      bus_read(A_STATUS, d);
      total++; if (d !== status_of(txq.size(), rxq.size())) begin
         bad++; $display("FAIL rnd_status_final: got %h expected %h", d, status_of(txq.size(), rxq.size()));
      end
   endtask

   initial begin
      test_reset();
      test_scratch();
      test_txq_full();
      test_rx_irq();
      test_rx_underflow();
      test_reset_midflight();
      test_loopback();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
